// File: rtl/uncache_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// Package: cpu_defines
// Purpose: shared types and constants for the uncached bus arbiter slice.
//   arb_state_t - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   arb_owner_t - which requester owns the current bus transaction
//   KSEG0_BASE / KSEG1_BASE / KSEG2_BASE - MIPS-style segment boundaries used
//   by the virtual-to-physical address strip.
// -----------------------------------------------------------------------------
package cpu_defines;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
  localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;

endpackage

// File: rtl/uncache_bus_arbiter_kseg_xlate.sv
// -----------------------------------------------------------------------------
// Module: kseg_xlate
// Purpose: purely combinational virtual-to-physical translation for the
//   unmapped segments. kseg1 and kseg0 addresses have their segment base
//   stripped; every other address passes through untouched.
// Ports:
//   vaddr_i  in  ADDR_W  virtual address
//   paddr_o  out ADDR_W  physical address
// -----------------------------------------------------------------------------
module kseg_xlate
  import cpu_defines::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] vaddr_i,
  output logic [ADDR_W-1:0] paddr_o
);

  localparam logic [ADDR_W-1:0] K0_BASE = ADDR_W'(KSEG0_BASE);
  localparam logic [ADDR_W-1:0] K1_BASE = ADDR_W'(KSEG1_BASE);
  localparam logic [ADDR_W-1:0] K2_BASE = ADDR_W'(KSEG2_BASE);

  // Segment decode: kseg1 occupies [K1_BASE, K2_BASE), kseg0 occupies
  // [K0_BASE, K1_BASE). Anything else (kuseg, kseg2/3) is passed through.
  always_comb begin
    paddr_o = vaddr_i;
    if (vaddr_i >= K1_BASE && vaddr_i < K2_BASE) begin
      paddr_o = vaddr_i - K1_BASE;
    end else if (vaddr_i >= K0_BASE && vaddr_i < K1_BASE) begin
      paddr_o = vaddr_i - K0_BASE;
    end
  end

endmodule

// File: rtl/uncache_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Module: uncache_bus_arbiter
// Purpose: shares one uncached SRAM-style bus port between the instruction
//   fetch (IF) and data (MEM) uncached paths. One transaction is outstanding
//   at a time; the winner's address is translated and registered, the bus is
//   driven from registers, and the response is routed back to the winner.
//   A WAIT phase longer than TIMEOUT cycles raises a sticky error and returns
//   a zero-data response so the requester never hangs.
// Configuration:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests go to the side
//   not granted last; otherwise MEM always beats IF.
// Ports:
//   clk, rst                          clock, async active-high reset
//   i_req_i, i_vaddr_i                IF read request
//   i_ack_o, i_rvalid_o, i_rdata_o    IF accept pulse / response
//   d_req_i, d_wr_i, d_vaddr_i,
//   d_wstrb_i, d_wdata_i              MEM read/write request
//   d_ack_o, d_rvalid_o, d_rdata_o    MEM accept pulse / response
//   bus_req_o, bus_wr_o, bus_addr_o,
//   bus_wstrb_o, bus_wdata_o          bus address/write phase
//   bus_addr_ok_i, bus_data_ok_i,
//   bus_rdata_i                       bus handshakes and read data
//   err_o                             sticky timeout flag
// -----------------------------------------------------------------------------
module uncache_bus_arbiter
  import cpu_defines::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_i,
  input  logic [ADDR_W-1:0]     i_vaddr_i,
  output logic                  i_ack_o,
  output logic                  i_rvalid_o,
  output logic [DATA_W-1:0]     i_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_wr_i,
  input  logic [ADDR_W-1:0]     d_vaddr_i,
  input  logic [DATA_W/8-1:0]   d_wstrb_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  output logic                  d_ack_o,
  output logic                  d_rvalid_o,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  bus_req_o,
  output logic                  bus_wr_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W/8-1:0]   bus_wstrb_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  input  logic                  bus_addr_ok_i,
  input  logic                  bus_data_ok_i,
  input  logic [DATA_W-1:0]     bus_rdata_i,
  output logic                  err_o
);

  localparam int STRB_W = DATA_W / 8;
  // The WAIT counter starts at 0 on the first WAIT cycle, so the last
  // allowed WAIT cycle is the one where it reads TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  arb_state_t          state_q;
  arb_owner_t          owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [7:0]          waitCnt_q;
  logic                err_q;
`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t          grant_q;
`endif

  logic                pickD_d;
  logic                accept_d;
  logic [ADDR_W-1:0]   vaddr_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic                wr_d;
  logic [STRB_W-1:0]   wstrb_d;
  logic [DATA_W-1:0]   wdata_d;

  // Arbitration and capture mux. Acceptance is blocked while rst is high so
  // a requester never sees an ack that the reset immediately discards.
  // IF is read-only, so its write fields are forced to zero here.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pickD_d = d_req_i && (!i_req_i || grant_q == OWN_I);
`else
    pickD_d = d_req_i;
`endif
    accept_d = !rst && (state_q == IDLE) && (i_req_i || d_req_i);
    vaddr_d  = pickD_d ? d_vaddr_i : i_vaddr_i;
    wr_d     = pickD_d && d_wr_i;
    wstrb_d  = wr_d ? d_wstrb_i : '0;
    wdata_d  = pickD_d ? d_wdata_i : '0;
  end

  kseg_xlate #(
    .ADDR_W (ADDR_W)
  ) u_xlate (
    .vaddr_i (vaddr_d),
    .paddr_o (paddr_d)
  );

  // Transaction FSM: capture in IDLE, hold the address phase in ISSUE until
  // the bus takes it, wait for data (bounded by the timeout) and present the
  // response for exactly one cycle in RESP. An addr_ok+data_ok pair in ISSUE
  // skips WAIT entirely. Any data_ok arriving outside ISSUE/WAIT is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_D;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      waitCnt_q <= '0;
      err_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      grant_q   <= OWN_D;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            owner_q <= pickD_d ? OWN_D : OWN_I;
            addr_q  <= paddr_d;
            wr_q    <= wr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            grant_q <= pickD_d ? OWN_D : OWN_I;
`endif
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus_addr_ok_i) begin
            waitCnt_q <= '0;
            if (bus_data_ok_i) begin
              rdata_q <= bus_rdata_i;
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus_data_ok_i) begin
            rdata_q <= bus_rdata_i;
            state_q <= RESP;
          end else if (waitCnt_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= RESP;
          end else begin
            waitCnt_q <= waitCnt_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Requester and bus outputs are decoded from registered state only, apart
  // from the same-cycle ack pulses.
  always_comb begin
    i_ack_o     = accept_d && !pickD_d;
    d_ack_o     = accept_d && pickD_d;
    i_rvalid_o  = (state_q == RESP) && (owner_q == OWN_I);
    d_rvalid_o  = (state_q == RESP) && (owner_q == OWN_D);
    i_rdata_o   = rdata_q;
    d_rdata_o   = rdata_q;
    bus_req_o   = (state_q == ISSUE);
    bus_wr_o    = wr_q;
    bus_addr_o  = addr_q;
    bus_wstrb_o = wstrb_q;
    bus_wdata_o = wdata_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_uncache_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench: tb_uncache_bus_arbiter
// Purpose: directed, table-driven check of uncache_bus_arbiter. A table of
//   single transactions (translation, latency, write fields) is applied in a
//   loop, followed by hand-written sequences for simultaneous requests,
//   timeout and reset in the middle of a transaction. Honours
//   ARB_ROUND_ROBIN_EN for the expected grant order.
// -----------------------------------------------------------------------------
module tb_uncache_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iReq;
  logic [31:0] iVaddr;
  logic        iAck;
  logic        iRvalid;
  logic [31:0] iRdata;
  logic        dReq;
  logic        dWr;
  logic [31:0] dVaddr;
  logic [3:0]  dWstrb;
  logic [31:0] dWdata;
  logic        dAck;
  logic        dRvalid;
  logic [31:0] dRdata;
  logic        busReq;
  logic        busWr;
  logic [31:0] busAddr;
  logic [3:0]  busWstrb;
  logic [31:0] busWdata;
  logic        busAddrOk;
  logic        busDataOk;
  logic [31:0] busRdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          isD;
    bit          wr;
    logic [31:0] vaddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          aCyc;
    int          dCyc;
    logic [31:0] rdata;
    logic [31:0] expAddr;
    logic [3:0]  expStrb;
  } vec_t;

  vec_t vecs [8];

  uncache_bus_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_i       (iReq),
    .i_vaddr_i     (iVaddr),
    .i_ack_o       (iAck),
    .i_rvalid_o    (iRvalid),
    .i_rdata_o     (iRdata),
    .d_req_i       (dReq),
    .d_wr_i        (dWr),
    .d_vaddr_i     (dVaddr),
    .d_wstrb_i     (dWstrb),
    .d_wdata_i     (dWdata),
    .d_ack_o       (dAck),
    .d_rvalid_o    (dRvalid),
    .d_rdata_o     (dRdata),
    .bus_req_o     (busReq),
    .bus_wr_o      (busWr),
    .bus_addr_o    (busAddr),
    .bus_wstrb_o   (busWstrb),
    .bus_wdata_o   (busWdata),
    .bus_addr_ok_i (busAddrOk),
    .bus_data_ok_i (busDataOk),
    .bus_rdata_i   (busRdata),
    .err_o         (err)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Moves to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every DUT output is expected to be zero (reset state).
  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ctrl"},
                32'({iAck, iRvalid, dAck, dRvalid, busReq, busWr, err, busWstrb}), 32'd0);
    checkOutput({tag, " busAddr"}, busAddr, 32'd0);
    checkOutput({tag, " busWdata"}, busWdata, 32'd0);
    checkOutput({tag, " rdata"}, iRdata | dRdata, 32'd0);
  endtask

  // One complete transaction from a table entry: request, ack, bus fields,
  // bus handshakes at the listed cycles, and the single-cycle response.
  task automatic applyStimulus(input vec_t v, input string tag);
    logic early;
    int   r;
    r     = v.dCyc + 1;
    early = 1'b0;
    tick();
    if (v.isD) begin
      dReq = 1'b1; dWr = v.wr; dVaddr = v.vaddr; dWstrb = v.wstrb; dWdata = v.wdata;
    end else begin
      iReq = 1'b1; iVaddr = v.vaddr;
    end
    #1;
    checkOutput({tag, " ack"}, 32'(v.isD ? dAck : iAck), 32'd1);
    checkOutput({tag, " otherAck"}, 32'(v.isD ? iAck : dAck), 32'd0);
    for (int k = 1; k <= r; k++) begin
      tick();
      if (k == 1) begin
        iReq = 1'b0; dReq = 1'b0;
        iVaddr = 32'hFFFF_FFFF; dVaddr = 32'hFFFF_FFFF;
        dWstrb = 4'hF; dWdata = 32'hFFFF_FFFF;
      end
      busAddrOk = (k == v.aCyc);
      busDataOk = (k == v.dCyc);
      busRdata  = (k == v.dCyc) ? v.rdata : 32'h5A5A_5A5A;
      #1;
      if (k == 1) begin
        checkOutput({tag, " busReq"}, 32'(busReq), 32'd1);
        checkOutput({tag, " busAddr"}, busAddr, v.expAddr);
        checkOutput({tag, " busWr"}, 32'(busWr), 32'(v.wr));
        checkOutput({tag, " busWstrb"}, 32'(busWstrb), 32'(v.expStrb));
        if (v.wr) checkOutput({tag, " busWdata"}, busWdata, v.wdata);
      end
      if (k == v.aCyc + 1 && k < r) begin
        checkOutput({tag, " busReqWait"}, 32'(busReq), 32'd0);
      end
      if (k < r) begin
        early = early | iRvalid | dRvalid;
      end else begin
        checkOutput({tag, " rvalid"}, 32'(v.isD ? dRvalid : iRvalid), 32'd1);
        checkOutput({tag, " otherRvalid"}, 32'(v.isD ? iRvalid : dRvalid), 32'd0);
        if (!v.wr) checkOutput({tag, " rdata"}, v.isD ? dRdata : iRdata, v.rdata);
      end
    end
    checkOutput({tag, " earlyRvalid"}, 32'(early), 32'd0);
    tick();
    busAddrOk = 1'b0; busDataOk = 1'b0;
    #1;
    checkOutput({tag, " rvalidPulse"}, 32'({iRvalid, dRvalid}), 32'd0);
  endtask

  // Both requesters hold their requests for 8 grants; the grant order shows
  // the arbitration policy. Afterwards MEM drops and IF must be accepted in
  // the IDLE cycle right after the last RESP.
  task automatic arbSequence();
    logic expI;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int g = 0; g < 8; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expI = (g % 2 == 0);
`else
      expI = 1'b0;
`endif
      tick();
      iReq = 1'b1; iVaddr = 32'h9FC0_0000;
      dReq = 1'b1; dWr = 1'b0; dVaddr = 32'h0000_2000; dWstrb = 4'h0;
      #1;
      checkOutput($sformatf("arb%0d iAck", g), 32'(iAck), 32'(expI));
      checkOutput($sformatf("arb%0d dAck", g), 32'(dAck), 32'(!expI));
      tick();
      busAddrOk = 1'b1; busDataOk = 1'b1; busRdata = 32'h100 + 32'(g);
      #1;
      checkOutput($sformatf("arb%0d busAddr", g), busAddr,
                  expI ? 32'h1FC0_0000 : 32'h0000_2000);
      checkOutput($sformatf("arb%0d ackInIssue", g), 32'({iAck, dAck}), 32'd0);
      tick();
      busAddrOk = 1'b0; busDataOk = 1'b0;
      #1;
      checkOutput($sformatf("arb%0d rvalid", g), 32'(expI ? iRvalid : dRvalid), 32'd1);
      checkOutput($sformatf("arb%0d ackInResp", g), 32'({iAck, dAck}), 32'd0);
    end
    tick();
    dReq = 1'b0;
    #1;
    checkOutput("arbLast iAck", 32'({iAck, dAck}), 32'b10);
    tick();
    iReq = 1'b0; busAddrOk = 1'b1; busDataOk = 1'b1; busRdata = 32'hC0DE_0001;
    #1;
    tick();
    busAddrOk = 1'b0; busDataOk = 1'b0;
    #1;
    checkOutput("arbLast iRvalid", 32'(iRvalid), 32'd1);
    checkOutput("arbLast iRdata", iRdata, 32'hC0DE_0001);
  endtask

  // data_ok never arrives: the 255th WAIT cycle must end the transaction
  // with err set and zero data; a late data_ok in IDLE must be ignored.
  task automatic timeoutSequence();
    int   n;
    logic found;
    tick();
    dReq = 1'b1; dWr = 1'b0; dVaddr = 32'h1000_0000;
    #1;
    checkOutput("to dAck", 32'(dAck), 32'd1);
    tick();
    dReq = 1'b0; busAddrOk = 1'b1; busDataOk = 1'b0; busRdata = 32'hFFFF_FFFF;
    #1;
    n = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      tick();
      busAddrOk = 1'b0;
      #1;
      n++;
      if (dRvalid) found = 1'b1;
      else if (n == 255) checkOutput("to errBefore", 32'(err), 32'd0);
    end
    checkOutput("to respCycle", 32'(n), 32'd256);
    checkOutput("to err", 32'(err), 32'd1);
    checkOutput("to dRdata", dRdata, 32'd0);
    tick();
    busDataOk = 1'b1;
    #1;
    checkOutput("to lateDataOk", 32'({iRvalid, dRvalid, iAck, dAck}), 32'd0);
    tick();
    busDataOk = 1'b0;
    #1;
    checkOutput("to lateDataOk2", 32'({iRvalid, dRvalid}), 32'd0);
    applyStimulus(vecs[0], "afterTimeout");
    checkOutput("to errSticky", 32'(err), 32'd1);
  endtask

  // Reset while the arbiter waits for write data: outputs clear at once,
  // the pending response is never delivered and the next request works.
  task automatic resetSequence();
    tick();
    dReq = 1'b1; dWr = 1'b1; dVaddr = 32'hA000_0040; dWstrb = 4'hF; dWdata = 32'hCAFE_F00D;
    #1;
    checkOutput("rs dAck", 32'(dAck), 32'd1);
    tick();
    dReq = 1'b0; busAddrOk = 1'b1;
    #1;
    checkOutput("rs busAddr", busAddr, 32'h0000_0040);
    tick();
    busAddrOk = 1'b0;
    #1;
    tick();
    #1;
    rst = 1'b1;
    #1;
    checkAllZero("midReset");
    tick();
    busDataOk = 1'b1;
    #1;
    checkOutput("rs rvalidInReset", 32'({iRvalid, dRvalid}), 32'd0);
    rst = 1'b0;
    tick();
    busDataOk = 1'b0;
    #1;
    checkOutput("rs rvalidAfter", 32'({iRvalid, dRvalid, busReq}), 32'd0);
    applyStimulus(vecs[2], "afterReset");
  endtask

  initial begin
    //          isD   wr    vaddr          strb  wdata          a  d  rdata          expAddr        expStrb
    vecs[0] = '{1'b1, 1'b0, 32'hBFAF_0010, 4'h0, 32'h0000_0000, 1, 3, 32'h1234_5678, 32'h1FAF_0010, 4'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_0100, 4'h3, 32'hDEAD_BEEF, 1, 2, 32'h0000_0000, 32'h0000_0100, 4'h3};
    vecs[2] = '{1'b0, 1'b0, 32'h9FC0_0000, 4'h0, 32'h0000_0000, 1, 1, 32'hAAAA_5555, 32'h1FC0_0000, 4'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_1000, 4'hC, 32'h1111_2222, 2, 4, 32'h0BAD_F00D, 32'h0000_1000, 4'h0};
    vecs[4] = '{1'b0, 1'b0, 32'hC000_0004, 4'h0, 32'h0000_0000, 3, 3, 32'h0F0F_0F0F, 32'hC000_0004, 4'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0000_0000, 1, 1, 32'h1357_9BDF, 32'h7FFF_FFFC, 4'h0};
    vecs[6] = '{1'b1, 1'b1, 32'hA000_0000, 4'hF, 32'h0123_4567, 1, 1, 32'h0000_0000, 32'h0000_0000, 4'hF};
    vecs[7] = '{1'b0, 1'b0, 32'hBFFF_FFFC, 4'h0, 32'h0000_0000, 2, 5, 32'h2468_ACE0, 32'h1FFF_FFFC, 4'h0};

    rst = 1'b1;
    iReq = 1'b0; iVaddr = 32'd0;
    dReq = 1'b0; dWr = 1'b0; dVaddr = 32'd0; dWstrb = 4'h0; dWdata = 32'd0;
    busAddrOk = 1'b0; busDataOk = 1'b0; busRdata = 32'd0;
    #12;
    checkAllZero("reset");
    @(posedge clk);
    #3;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    arbSequence();
    timeoutSequence();
    resetSequence();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
